ram_rw_seq: RTL and testbench

//  Read/write sequencer driving the single-port RAM IP in the ip_1port_ram top.

---
 rtl/ram_rw_seq_pkg.sv | 20 ++
 rtl/ram_rd_chk.sv | 38 +++
 rtl/ram_rw_seq.sv | 141 ++++++++++++++
 tb/tb_ram_rw_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rw_seq_pkg.sv
// Shared state encoding and counter constants for the RAM read/write sequencer.
package ram_rw_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } seq_state_t;

   localparam int unsigned PASS_CNT_W = 16;
   localparam int unsigned ERR_CNT_W  = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ram_rd_chk.sv
// Read-data checker: carries issue-valid and expected data alongside the RAM
// read latency and flags a one-clock mismatch when the returned word is wrong.
module ram_rd_chk #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_issue,
   input  logic [DATA_W-1:0] i_exp,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_mismatch
);

   localparam int unsigned LAST = RD_LAT - 1;

   logic              r_vld [RD_LAT];
   logic [DATA_W-1:0] r_exp [RD_LAT];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            r_vld[i] <= 1'b0;
            r_exp[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_issue;
         r_exp[0] <= i_exp;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_exp[i] <= r_exp[i-1];
         end
      end
   end

   assign o_mismatch = r_vld[LAST] && (i_rd_data != r_exp[LAST]);

endmodule

// File: rtl/ram_rw_seq.sv
// RAM BIST sequencer: writes a seeded ramp, reads it back, counts miscompares
// and completed passes.
module ram_rw_seq
   import ram_rw_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned LOOP   = 1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   output logic                  ram_en,
   output logic                  ram_rw_en,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wr_data,
   input  logic [DATA_W-1:0]     ram_rd_data,
   output logic                  pass_done,
   output logic [PASS_CNT_W-1:0] pass_cnt,
   output logic                  err_flag,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam int unsigned       LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);

   seq_state_t            r_state;
   seq_state_t            w_state_nxt;
   logic [LAT_W-1:0]      r_lat;
   logic [LAT_W-1:0]      w_lat_nxt;
   logic [ADDR_W-1:0]     w_addr_nxt;
   logic                  w_pass_end;
   logic [DATA_W-1:0]     r_seed;

   logic                  r_ram_en;
   logic                  r_ram_rw_en;
   logic [ADDR_W-1:0]     r_ram_addr;
   logic [DATA_W-1:0]     r_ram_wr_data;
   logic                  r_pass_done;
   logic [PASS_CNT_W-1:0] r_pass_cnt;
   logic                  r_err_flag;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   logic                  w_rd_issue;
   logic [DATA_W-1:0]     w_rd_exp;
   logic                  w_mismatch;

   // The registered address output doubles as the phase address counter.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = '0;
      w_lat_nxt   = '0;
      w_pass_end  = 1'b0;
      unique case (r_state)
         IDLE: w_state_nxt = WRITE;
         WRITE: begin
            if (r_ram_addr == ADDR_LAST) w_state_nxt = READ;
            else                         w_addr_nxt  = r_ram_addr + 1'b1;
         end
         READ: begin
            if (r_ram_addr == ADDR_LAST) w_state_nxt = DRAIN;
            else                         w_addr_nxt  = r_ram_addr + 1'b1;
         end
         DRAIN: begin
            if (r_lat == LAT_LAST) begin
               w_state_nxt = DONE;
               w_pass_end  = 1'b1;
            end else begin
               w_lat_nxt = r_lat + 1'b1;
            end
         end
         DONE: begin
            if (LOOP != 0) w_state_nxt = WRITE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state       <= IDLE;
         r_lat         <= '0;
         r_seed        <= '0;
         r_ram_en      <= 1'b0;
         r_ram_rw_en   <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_wr_data <= '0;
         r_pass_done   <= 1'b0;
         r_pass_cnt    <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_lat         <= w_lat_nxt;
         r_ram_en      <= (w_state_nxt == WRITE) || (w_state_nxt == READ);
         r_ram_rw_en   <= (w_state_nxt == WRITE);
         r_ram_addr    <= w_addr_nxt;
         r_ram_wr_data <= (w_state_nxt == WRITE) ? DATA_W'(w_addr_nxt) + r_seed : '0;
         r_pass_done   <= w_pass_end;
         // Seed advances only once the pass's last compare has resolved.
         if (w_pass_end) begin
            r_pass_cnt <= r_pass_cnt + 1'b1;
            r_seed     <= r_seed + 1'b1;
         end
      end
   end

   assign w_rd_issue = r_ram_en && !r_ram_rw_en;
   assign w_rd_exp   = DATA_W'(r_ram_addr) + r_seed;

   ram_rd_chk #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_chk (
      .i_clk      (sys_clk),
      .i_rst_n    (sys_rst_n),
      .i_issue    (w_rd_issue),
      .i_exp      (w_rd_exp),
      .i_rd_data  (ram_rd_data),
      .o_mismatch (w_mismatch)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_err_flag <= 1'b0;
         r_err_cnt  <= '0;
      end else if (w_mismatch) begin
         r_err_flag <= 1'b1;
         r_err_cnt  <= sat_inc(r_err_cnt);
      end
   end

   assign ram_en      = r_ram_en;
   assign ram_rw_en   = r_ram_rw_en;
   assign ram_addr    = r_ram_addr;
   assign ram_wr_data = r_ram_wr_data;
   assign pass_done   = r_pass_done;
   assign pass_cnt    = r_pass_cnt;
   assign err_flag    = r_err_flag;
   assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_ram_rw_seq.sv
// Bench for ram_rw_seq: behavioural RAMs with injectable read faults, and a
// queue scoreboard for write transactions and end-of-pass status.
module tb_ram_rw_seq;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct packed {
      logic [15:0] cnt;
      logic [7:0]  errs;
      logic        flag;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   wr_t wq_a[$], wq_b[$];
   ev_t eq_a[$], eq_b[$];
   int  f_a, f_b;

   logic              rst_a, en_a, rw_a, done_a, flag_a;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] wd_a, rd_a;
   logic [15:0]       pc_a;
   logic [7:0]        ec_a;

   logic              rst_b, en_b, rw_b, done_b, flag_b;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] wd_b, rd_b;
   logic [15:0]       pc_b;
   logic [7:0]        ec_b;

   ram_rw_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .LOOP(1)) u_dut_a (
      .sys_clk(clk), .sys_rst_n(rst_a), .ram_en(en_a), .ram_rw_en(rw_a),
      .ram_addr(addr_a), .ram_wr_data(wd_a), .ram_rd_data(rd_a),
      .pass_done(done_a), .pass_cnt(pc_a), .err_flag(flag_a), .err_cnt(ec_a)
   );

   ram_rw_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .LOOP(0)) u_dut_b (
      .sys_clk(clk), .sys_rst_n(rst_b), .ram_en(en_b), .ram_rw_en(rw_b),
      .ram_addr(addr_b), .ram_wr_data(wd_b), .ram_rd_data(rd_b),
      .pass_done(done_b), .pass_cnt(pc_b), .err_flag(flag_b), .err_cnt(ec_b)
   );

   // 1: addr 7 reads as 0x00; 2: bit0 stuck at 1; 3: bit0 inverted.
   function automatic logic [DATA_W-1:0] fault(input int mode, input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] d);
      case (mode)
         1:       return (a == ADDR_W'(7)) ? '0 : d;
         2:       return d | DATA_W'(1);
         3:       return d ^ DATA_W'(1);
         default: return d;
      endcase
   endfunction

   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] pipe_a;
   always @(posedge clk) begin
      if (en_a && rw_a)  mem_a[addr_a] <= wd_a;
      if (en_a && !rw_a) pipe_a <= fault(f_a, addr_a, mem_a[addr_a]);
   end
   assign rd_a = pipe_a;

   logic [DATA_W-1:0] mem_b [DEPTH];
   logic [DATA_W-1:0] pipe_b [3];
   always @(posedge clk) begin
      if (en_b && rw_b) mem_b[addr_b] <= wd_b;
      pipe_b[0] <= fault(f_b, addr_b, mem_b[addr_b]);
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign rd_b = pipe_b[2];

   function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   wr_t wa, wb;
   ev_t ea, eb;

   always @(negedge clk) begin
      if (rst_a && en_a && rw_a) begin
         if (wq_a.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL wr_a: unexpected write addr=%0d data=%02h, none queued", addr_a, wd_a);
         end else begin
            wa = wq_a.pop_front();
            check("wr_a_addr", 32'(addr_a), 32'(wa.addr));
            check("wr_a_data", 32'(wd_a), 32'(wa.data));
         end
      end
      if (rst_a && done_a) begin
         if (eq_a.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL pass_a: unexpected pass_done pass_cnt=%0d, none queued", pc_a);
         end else begin
            ea = eq_a.pop_front();
            check("pass_cnt_a", 32'(pc_a), 32'(ea.cnt));
            check("err_cnt_a", 32'(ec_a), 32'(ea.errs));
            check("err_flag_a", 32'(flag_a), 32'(ea.flag));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_b && en_b && rw_b) begin
         if (wq_b.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL wr_b: unexpected write addr=%0d data=%02h, none queued", addr_b, wd_b);
         end else begin
            wb = wq_b.pop_front();
            check("wr_b_addr", 32'(addr_b), 32'(wb.addr));
            check("wr_b_data", 32'(wd_b), 32'(wb.data));
         end
      end
      if (rst_b && done_b) begin
         if (eq_b.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL pass_b: unexpected pass_done pass_cnt=%0d, none queued", pc_b);
         end else begin
            eb = eq_b.pop_front();
            check("pass_cnt_b", 32'(pc_b), 32'(eb.cnt));
            check("err_cnt_b", 32'(ec_b), 32'(eb.errs));
            check("err_flag_b", 32'(flag_b), 32'(eb.flag));
         end
      end
   end

   task automatic push_pass(input int d, input logic [7:0] seed, input logic [15:0] cnt,
                            input logic [7:0] errs, input logic flag);
      wr_t w;
      ev_t e;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         w.addr = ADDR_W'(k);
         w.data = DATA_W'(k) + seed;
         if (d == 0) wq_a.push_back(w);
         else        wq_b.push_back(w);
      end
      e.cnt  = cnt;
      e.errs = errs;
      e.flag = flag;
      if (d == 0) eq_a.push_back(e);
      else        eq_b.push_back(e);
   endtask

   function automatic int pending(input int d);
      return (d == 0) ? (wq_a.size() + eq_a.size()) : (wq_b.size() + eq_b.size());
   endfunction

   task automatic wait_empty(input int d, input int unsigned budget, input string nm);
      int unsigned n = 0;
      while (pending(d) != 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check(nm, 32'(pending(d)), 32'(0));
   endtask

   task automatic wait_read(input int d, input logic [ADDR_W-1:0] a, input string nm);
      int unsigned n = 0;
      logic hit;
      hit = 1'b0;
      while (!hit && n < 400) begin
         @(negedge clk); #1;
         n++;
         hit = (d == 0) ? (en_a && !rw_a && addr_a == a) : (en_b && !rw_b && addr_b == a);
      end
      check(nm, 32'(hit), 32'(1));
   endtask

   task automatic check_rst(input int d, input string nm);
      if (d == 0) begin
         check({nm, "_ctl"}, 32'({en_a, rw_a, done_a, flag_a}), 32'(0));
         check({nm, "_addr"}, 32'(addr_a), 32'(0));
         check({nm, "_wdata"}, 32'(wd_a), 32'(0));
         check({nm, "_cnts"}, {pc_a, ec_a, 8'h00}, 32'(0));
      end else begin
         check({nm, "_ctl"}, 32'({en_b, rw_b, done_b, flag_b}), 32'(0));
         check({nm, "_addr"}, 32'(addr_b), 32'(0));
         check({nm, "_wdata"}, 32'(wd_b), 32'(0));
         check({nm, "_cnts"}, {pc_b, ec_b, 8'h00}, 32'(0));
      end
   endtask

   initial begin
      int unsigned k;
      logic        bad;
      rst_a = 1'b0; rst_b = 1'b0; f_a = 0; f_b = 0;
      repeat (2) @(negedge clk);
      #1;
      check_rst(0, "rst_a");
      check_rst(1, "rst_b");

      // 300 clean passes: seed ramps and wraps 255->0.
      for (int p = 0; p < 300; p++) push_pass(0, 8'(p), 16'(p + 1), 8'd0, 1'b0);
      @(negedge clk); rst_a = 1'b1;
      wait_empty(0, 300 * 70 + 100, "a_300_passes");
      rst_a = 1'b0; #1;
      check_rst(0, "rst_a_after300");
      wq_a.delete(); eq_a.delete();

      // Single bad word at addr 7 in pass 0 only.
      f_a = 1;
      push_pass(0, 8'd0, 16'd1, 8'd1, 1'b1);
      push_pass(0, 8'd1, 16'd2, 8'd1, 1'b1);
      push_pass(0, 8'd2, 16'd3, 8'd1, 1'b1);
      @(negedge clk); rst_a = 1'b1;
      wait_read(0, ADDR_W'(7), "a_read7_seen");
      k = 0;
      while (!flag_a && k < 10) begin
         @(negedge clk); #1;
         k++;
      end
      check("a_errflag_latency", 32'(k), 32'(2));
      f_a = 0;
      wait_empty(0, 3 * 70 + 100, "a_addr7_passes");
      rst_a = 1'b0; #1;
      wq_a.delete(); eq_a.delete();

      // Stuck bit0: 16 miscompares per pass, saturating at 255.
      f_a = 2;
      for (int n = 1; n <= 20; n++)
         push_pass(0, 8'(n - 1), 16'(n), (16 * n > 255) ? 8'd255 : 8'(16 * n), 1'b1);
      @(negedge clk); rst_a = 1'b1;
      wait_empty(0, 20 * 70 + 100, "a_stuck_passes");
      check("a_err_sat_hold", 32'({flag_a, ec_a}), 32'({1'b1, 8'd255}));
      rst_a = 1'b0; #1;
      f_a = 0;
      wq_a.delete(); eq_a.delete();

      // Reset in the middle of the read phase.
      push_pass(0, 8'd0, 16'd1, 8'd0, 1'b0);
      @(negedge clk); rst_a = 1'b1;
      wait_read(0, ADDR_W'(12), "a_read12_seen");
      rst_a = 1'b0; #1;
      check_rst(0, "rst_a_midread");
      wq_a.delete(); eq_a.delete();
      push_pass(0, 8'd0, 16'd1, 8'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      wait_empty(0, 200, "a_restart_pass");
      rst_a = 1'b0;

      // RD_LAT=3, LOOP=0: drain length, then a quiet DONE.
      push_pass(1, 8'd0, 16'd1, 8'd0, 1'b0);
      @(negedge clk); rst_b = 1'b1;
      wait_read(1, ADDR_W'(31), "b_read31_seen");
      k = 0;
      while (!done_b && k < 10) begin
         @(negedge clk); #1;
         k++;
      end
      check("b_read31_to_done", 32'(k), 32'(4));
      wait_empty(1, 50, "b_pass0");
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk); #1;
         bad = bad | en_b | done_b;
      end
      check("b_loop0_idle", 32'(bad), 32'(0));
      check("b_pass_cnt_hold", 32'(pc_b), 32'(1));

      // Every word corrupted: exactly one compare per address.
      rst_b = 1'b0; #1;
      f_b = 3;
      push_pass(1, 8'd0, 16'd1, 8'd32, 1'b1);
      @(negedge clk); rst_b = 1'b1;
      wait_empty(1, 200, "b_all_bad_pass");
      rst_b = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1);
   end

endmodule
